// File: rtl/risc8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc8_pkg
//  Description : Shared encodings for the 8-bit single-bus CPU control path:
//                sequencer states, bus driver codes, opcodes, ALU codes and
//                the opcode class produced by the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc8_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FA     = 4'd1,   // fetch address: PC -> MAR
        ST_FD     = 4'd2,   // fetch data: MEM -> IR
        ST_DEC    = 4'd3,
        ST_EX_ALU = 4'd4,
        ST_EX_MOV = 4'd5,
        ST_SKIP   = 4'd6,   // not-taken branch: step over the operand byte
        ST_OA     = 4'd7,   // operand address: PC -> MAR
        ST_OD     = 4'd8,   // operand data: MEM -> destination
        ST_HALT   = 4'd9
    } seq_state_t;

    // Opcode classes reported by the decoder
    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_HLT = 3'd1,
        CLS_ALU = 3'd2,
        CLS_MOV = 3'd3,
        CLS_LD  = 3'd4,
        CLS_JMP = 3'd5,
        CLS_ILL = 3'd6
    } op_class_t;

    // Bus driver select codes
    localparam logic [2:0] DRV_NONE = 3'd0;
    localparam logic [2:0] DRV_PC   = 3'd1;
    localparam logic [2:0] DRV_MEM  = 3'd2;
    localparam logic [2:0] DRV_REGA = 3'd3;
    localparam logic [2:0] DRV_REGB = 3'd4;
    localparam logic [2:0] DRV_ALU  = 3'd5;

    // Opcodes
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_HLT    = 8'h01;
    localparam logic [4:0] OP_ALU_HI = 5'b00010;  // 0x10-0x17, op in ir[2:0]
    localparam logic [7:0] OP_LDA    = 8'h20;
    localparam logic [7:0] OP_LDB    = 8'h21;
    localparam logic [7:0] OP_MOV_BA = 8'h22;     // B <= A
    localparam logic [7:0] OP_MOV_AB = 8'h23;     // A <= B
    localparam logic [7:0] OP_JMP    = 8'h30;
    localparam logic [7:0] OP_JZ     = 8'h31;
    localparam logic [7:0] OP_JC     = 8'h32;

    // ALU opcodes, identical to the ALU's own encoding
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_INC = 3'b010;
    localparam logic [2:0] ALU_DEC = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_ADC = 3'b111;

    // State that follows the last cycle of an instruction
    function automatic seq_state_t boundary_next(input logic run);
        seq_state_t nxt;
        if (run) nxt = ST_FA;
        else     nxt = ST_IDLE;
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_seq_decode.sv
`default_nettype none
// ============================================================================
//  Module      : bus_seq_decode
//  Description : Combinational opcode classifier for the bus sequencer.
//                Reports the instruction class, the ALU opcode, whether a
//                (conditional) jump is taken and whether the opcode is
//                undefined.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_seq_decode
    import risc8_pkg::*;
(
    input  logic [7:0] ir,
    input  logic       flag_z,
    input  logic       flag_c,
    output op_class_t  op_class,
    output logic [2:0] alu_op,
    output logic       jump_taken,
    output logic       illegal
);

    // Classify the opcode; anything not matched stays illegal
    always_comb begin
        op_class   = CLS_ILL;
        alu_op     = ALU_ADD;
        jump_taken = 1'b0;
        if (ir[7:3] == OP_ALU_HI) begin
            op_class = CLS_ALU;
            alu_op   = ir[2:0];
        end else begin
            case (ir)
                OP_NOP:    op_class = CLS_NOP;
                OP_HLT:    op_class = CLS_HLT;
                OP_LDA,
                OP_LDB:    op_class = CLS_LD;
                OP_MOV_BA,
                OP_MOV_AB: op_class = CLS_MOV;
                OP_JMP: begin
                    op_class   = CLS_JMP;
                    jump_taken = 1'b1;
                end
                OP_JZ: begin
                    op_class   = CLS_JMP;
                    jump_taken = flag_z;
                end
                OP_JC: begin
                    op_class   = CLS_JMP;
                    jump_taken = flag_c;
                end
                default:   op_class = CLS_ILL;
            endcase
        end
    end

    assign illegal = (op_class == CLS_ILL);

endmodule
`default_nettype wire

// File: rtl/bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sequencer
//  Description : Fetch/decode/execute control sequencer for the 8-bit
//                single-bus CPU. Selects one bus driver per cycle, pulses
//                destination write strobes, drives the ALU opcode, advances
//                the PC and waits on memory with an optional timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_sequencer
    import risc8_pkg::*;
#(
    parameter int WAIT_LIMIT = 0    // max consecutive wait cycles, 0 = unlimited
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [7:0] ir,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       mem_ready,
    output logic [2:0] drv_sel,
    output logic       mem_rd,
    output logic       mar_we,
    output logic       ir_we,
    output logic       rega_we,
    output logic       regb_we,
    output logic       pc_we,
    output logic       pc_inc,
    output logic       flags_we,
    output logic [2:0] alu_op,
    output logic [3:0] step,
    output logic       halted,
    output logic       illegal_op,
    output logic       bus_err
);

    // Wait counter only needs to hold 0..WAIT_LIMIT-1: the cycle that would
    // make it reach WAIT_LIMIT is the timeout cycle itself.
    localparam int              c_WCW       = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [c_WCW-1:0] c_WAIT_LAST = c_WCW'(WAIT_LIMIT - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [3:0]       r_step;
    logic [c_WCW-1:0] r_wait_cnt;
    logic             r_bus_err;
    logic             w_in_mem_wait;
    logic             w_wait_hit;

    op_class_t        w_op_class;
    logic [2:0]       w_alu_op;
    logic             w_jump_taken;
    logic             w_illegal;

    bus_seq_decode u_decode (
        .ir         (ir),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .op_class   (w_op_class),
        .alu_op     (w_alu_op),
        .jump_taken (w_jump_taken),
        .illegal    (w_illegal)
    );

    assign w_in_mem_wait = ((r_state == ST_FD) || (r_state == ST_OD)) && !mem_ready;
    assign w_wait_hit    = (WAIT_LIMIT > 0) && w_in_mem_wait && (r_wait_cnt == c_WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and per-state control outputs
    always_comb begin
        w_state_nxt = r_state;
        drv_sel     = DRV_NONE;
        mem_rd      = 1'b0;
        mar_we      = 1'b0;
        ir_we       = 1'b0;
        rega_we     = 1'b0;
        regb_we     = 1'b0;
        pc_we       = 1'b0;
        pc_inc      = 1'b0;
        flags_we    = 1'b0;
        alu_op      = ALU_ADD;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_state_nxt = ST_FA;
            end
            ST_FA: begin
                drv_sel     = DRV_PC;
                mar_we      = 1'b1;
                w_state_nxt = ST_FD;
            end
            ST_FD: begin
                drv_sel = DRV_MEM;
                mem_rd  = 1'b1;
                if (mem_ready) begin
                    ir_we       = 1'b1;
                    pc_inc      = 1'b1;
                    w_state_nxt = ST_DEC;
                end else if (w_wait_hit) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_DEC: begin
                illegal_op = w_illegal;
                case (w_op_class)
                    CLS_HLT: w_state_nxt = ST_HALT;
                    CLS_ALU: w_state_nxt = ST_EX_ALU;
                    CLS_MOV: w_state_nxt = ST_EX_MOV;
                    CLS_LD:  w_state_nxt = ST_OA;
                    CLS_JMP: w_state_nxt = w_jump_taken ? ST_OA : ST_SKIP;
                    default: w_state_nxt = boundary_next(run);   // NOP, illegal
                endcase
            end
            ST_EX_ALU: begin
                drv_sel     = DRV_ALU;
                alu_op      = w_alu_op;
                rega_we     = 1'b1;
                flags_we    = 1'b1;
                w_state_nxt = boundary_next(run);
            end
            ST_EX_MOV: begin
                if (ir == OP_MOV_BA) begin
                    drv_sel = DRV_REGA;
                    regb_we = 1'b1;
                end else begin
                    drv_sel = DRV_REGB;
                    rega_we = 1'b1;
                end
                w_state_nxt = boundary_next(run);
            end
            ST_SKIP: begin
                pc_inc      = 1'b1;
                w_state_nxt = boundary_next(run);
            end
            ST_OA: begin
                drv_sel     = DRV_PC;
                mar_we      = 1'b1;
                w_state_nxt = ST_OD;
            end
            ST_OD: begin
                drv_sel = DRV_MEM;
                mem_rd  = 1'b1;
                if (mem_ready) begin
                    if (w_op_class == CLS_LD) begin
                        // the operand byte is consumed, so the PC moves past it
                        if (ir == OP_LDB) regb_we = 1'b1;
                        else              rega_we = 1'b1;
                        pc_inc = 1'b1;
                    end else begin
                        pc_we = 1'b1;
                    end
                    w_state_nxt = boundary_next(run);
                end else if (w_wait_hit) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Cycle index within the instruction; restarts at FA, parked at 0 otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step <= 4'd0;
        end else if ((w_state_nxt == ST_FA) || (w_state_nxt == ST_IDLE) ||
                     (w_state_nxt == ST_HALT)) begin
            r_step <= 4'd0;
        end else if (r_step != 4'hF) begin
            r_step <= r_step + 4'd1;
        end
    end

    // Consecutive memory wait cycles; any non-wait cycle (including FA/OA
    // before each access) clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if ((WAIT_LIMIT > 0) && w_in_mem_wait && !w_wait_hit) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Sticky bus error on memory timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_bus_err <= 1'b0;
        else if (w_wait_hit) r_bus_err <= 1'b1;
    end

    assign step    = r_step;
    assign bus_err = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_sequencer
//  Description : Self-checking bench for bus_sequencer. Builds the expected
//                per-cycle control trace of each instruction from the
//                instruction-level timing rules and compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_sequencer;

    // strobe field bits: mem_rd, mar_we, ir_we, rega_we, regb_we, pc_we, pc_inc, flags_we
    localparam logic [7:0] S_MRD = 8'h80;
    localparam logic [7:0] S_MAR = 8'h40;
    localparam logic [7:0] S_IRW = 8'h20;
    localparam logic [7:0] S_RA  = 8'h10;
    localparam logic [7:0] S_RB  = 8'h08;
    localparam logic [7:0] S_PCW = 8'h04;
    localparam logic [7:0] S_PCI = 8'h02;
    localparam logic [7:0] S_FLG = 8'h01;

    localparam int K_NOP = 0, K_ALU = 1, K_MOV = 2, K_OPND = 3, K_SKIP = 4, K_HLT = 5;

    logic       clk = 1'b0;
    logic       reset_n, reset_w_n, run, mem_ready, flag_z, flag_c;
    logic [7:0] ir;

    logic [2:0] m_drv_sel, m_alu_op, w_drv_sel, w_alu_op;
    logic [3:0] m_step, w_step;
    logic       m_mem_rd, m_mar_we, m_ir_we, m_rega_we, m_regb_we, m_pc_we, m_pc_inc;
    logic       m_flags_we, m_halted, m_illegal_op, m_bus_err;
    logic       w_mem_rd, w_mar_we, w_ir_we, w_rega_we, w_regb_we, w_pc_we, w_pc_inc;
    logic       w_flags_we, w_halted, w_illegal_op, w_bus_err;
    logic [20:0] obs_m, obs_w;

    typedef struct {
        logic        run;
        logic        rdy;
        logic [7:0]  irv;
        logic        z;
        logic        c;
        logic [20:0] exp;
    } ent_t;

    ent_t       q[$];
    logic [7:0] cur_ir;
    logic       cur_z, cur_c;
    int         cyc;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_cyc    = 0;

    always #5 clk = ~clk;

    bus_sequencer #(.WAIT_LIMIT(0)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .ir(ir), .flag_z(flag_z),
        .flag_c(flag_c), .mem_ready(mem_ready), .drv_sel(m_drv_sel),
        .mem_rd(m_mem_rd), .mar_we(m_mar_we), .ir_we(m_ir_we),
        .rega_we(m_rega_we), .regb_we(m_regb_we), .pc_we(m_pc_we),
        .pc_inc(m_pc_inc), .flags_we(m_flags_we), .alu_op(m_alu_op),
        .step(m_step), .halted(m_halted), .illegal_op(m_illegal_op),
        .bus_err(m_bus_err)
    );

    bus_sequencer #(.WAIT_LIMIT(4)) dut_w (
        .clk(clk), .reset_n(reset_w_n), .run(run), .ir(ir), .flag_z(flag_z),
        .flag_c(flag_c), .mem_ready(mem_ready), .drv_sel(w_drv_sel),
        .mem_rd(w_mem_rd), .mar_we(w_mar_we), .ir_we(w_ir_we),
        .rega_we(w_rega_we), .regb_we(w_regb_we), .pc_we(w_pc_we),
        .pc_inc(w_pc_inc), .flags_we(w_flags_we), .alu_op(w_alu_op),
        .step(w_step), .halted(w_halted), .illegal_op(w_illegal_op),
        .bus_err(w_bus_err)
    );

    assign obs_m = {m_drv_sel, m_mem_rd, m_mar_we, m_ir_we, m_rega_we, m_regb_we, m_pc_we,
                    m_pc_inc, m_flags_we, m_alu_op, m_step, m_halted, m_illegal_op, m_bus_err};
    assign obs_w = {w_drv_sel, w_mem_rd, w_mar_we, w_ir_we, w_rega_we, w_regb_we, w_pc_we,
                    w_pc_inc, w_flags_we, w_alu_op, w_step, w_halted, w_illegal_op, w_bus_err};

    task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic r, input logic rdy, input logic [2:0] drv,
                        input logic [7:0] stb, input logic [2:0] aop, input logic hl,
                        input logic ill, input logic be, input logic [3:0] stp);
        ent_t e;
        e.run = r;  e.rdy = rdy;  e.irv = cur_ir;  e.z = cur_z;  e.c = cur_c;
        e.exp = {drv, stb, aop, stp, hl, ill, be};
        q.push_back(e);
    endtask

    // one cycle inside an instruction; step counts from 0 and saturates at 15
    task automatic icyc(input logic r, input logic rdy, input logic [2:0] drv,
                        input logic [7:0] stb, input logic [2:0] aop, input logic ill);
        push(r, rdy, drv, stb, aop, 1'b0, ill, 1'b0, (cyc > 15) ? 4'd15 : 4'(cyc));
        cyc++;
    endtask

    task automatic push_idle();
        push(1'b1, rb(), 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Expected trace of one instruction: op fetched after wf wait cycles,
    // operand (if any) after wo wait cycles, run sampled at the last cycle.
    task automatic gen_instr(input logic [7:0] op, input logic z, input logic c,
                             input int wf, input int wo, input logic run_end);
        int   kind;
        logic ill;
        logic [7:0] fin;
        ill  = 1'b0;
        if (op >= 8'h10 && op <= 8'h17)            kind = K_ALU;
        else if (op == 8'h00)                      kind = K_NOP;
        else if (op == 8'h01)                      kind = K_HLT;
        else if (op == 8'h22 || op == 8'h23)       kind = K_MOV;
        else if (op == 8'h20 || op == 8'h21 || op == 8'h30) kind = K_OPND;
        else if (op == 8'h31)                      kind = z ? K_OPND : K_SKIP;
        else if (op == 8'h32)                      kind = c ? K_OPND : K_SKIP;
        else begin
            kind = K_NOP;
            ill  = 1'b1;
        end
        cyc   = 0;
        cur_z = z;
        cur_c = c;
        icyc(rb(), rb(), 3'd1, S_MAR, 3'd0, 1'b0);
        repeat (wf) icyc(rb(), 1'b0, 3'd2, S_MRD, 3'd0, 1'b0);
        icyc(rb(), 1'b1, 3'd2, S_MRD | S_IRW | S_PCI, 3'd0, 1'b0);
        cur_ir = op;
        if (kind == K_NOP) begin
            icyc(run_end, rb(), 3'd0, 8'h00, 3'd0, ill);
        end else begin
            icyc(rb(), rb(), 3'd0, 8'h00, 3'd0, 1'b0);
            case (kind)
                K_ALU:  icyc(run_end, rb(), 3'd5, S_RA | S_FLG, op[2:0], 1'b0);
                K_MOV:  if (op == 8'h22) icyc(run_end, rb(), 3'd3, S_RB, 3'd0, 1'b0);
                        else             icyc(run_end, rb(), 3'd4, S_RA, 3'd0, 1'b0);
                K_SKIP: icyc(run_end, rb(), 3'd0, S_PCI, 3'd0, 1'b0);
                K_OPND: begin
                    if (op == 8'h20)      fin = S_MRD | S_RA | S_PCI;
                    else if (op == 8'h21) fin = S_MRD | S_RB | S_PCI;
                    else                  fin = S_MRD | S_PCW;
                    icyc(rb(), rb(), 3'd1, S_MAR, 3'd0, 1'b0);
                    repeat (wo) icyc(rb(), 1'b0, 3'd2, S_MRD, 3'd0, 1'b0);
                    icyc(run_end, 1'b1, 3'd2, fin, 3'd0, 1'b0);
                end
                default: ;
            endcase
        end
        if (kind != K_HLT && !run_end) push_idle();
    endtask

    task automatic run_trace(input logic use_w, input int keep);
        ent_t e;
        while (q.size() > keep) begin
            e = q.pop_front();
            @(posedge clk);
            #1;
            run = e.run;  mem_ready = e.rdy;  ir = e.irv;  flag_z = e.z;  flag_c = e.c;
            @(negedge clk);
            chk($sformatf("cycle%0d", n_cyc), use_w ? obs_w : obs_m, e.exp);
            n_cyc++;
        end
    endtask

    initial begin
        logic [7:0] ops [20];
        ent_t e;
        ops = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20,
                8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h02, 8'h18, 8'h33, 8'hFF};
        reset_n = 1'b0;  reset_w_n = 1'b0;  run = 1'b0;  mem_ready = 1'b0;
        ir = 8'h00;  flag_z = 1'b0;  flag_c = 1'b0;
        cur_ir = 8'h00;  cur_z = 1'b0;  cur_c = 1'b0;

        // reset state, even with run and ready asserted
        @(negedge clk);
        chk("reset_state", obs_m, 21'd0);
        run = 1'b1;  mem_ready = 1'b1;
        @(negedge clk);
        chk("reset_run_high", obs_m, 21'd0);
        run = 1'b0;
        reset_n = 1'b1;

        // directed instructions, then random ones, then HLT
        push_idle();
        gen_instr(8'h00, 1'b0, 1'b0, 0, 0, 1'b1);
        gen_instr(8'h17, 1'b0, 1'b0, 0, 0, 1'b1);
        gen_instr(8'h20, 1'b0, 1'b0, 0, 2, 1'b1);
        gen_instr(8'h31, 1'b0, 1'b0, 0, 0, 1'b1);
        gen_instr(8'h31, 1'b1, 1'b0, 0, 0, 1'b1);
        gen_instr(8'hFF, 1'b0, 1'b0, 0, 0, 1'b0);
        gen_instr(8'h00, 1'b0, 1'b0, 20, 0, 1'b1);   // long wait, no limit
        run_trace(1'b0, 0);
        for (int i = 0; i < 150; i++) begin
            gen_instr(ops[$urandom_range(0, 19)], rb(), rb(), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0));
            run_trace(1'b0, 0);
        end
        gen_instr(8'h01, 1'b0, 1'b0, 1, 0, 1'b1);
        repeat (6) push(rb(), rb(), 3'd0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        run_trace(1'b0, 0);

        // reset leaves HALT immediately
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk("halt_reset", obs_m, 21'd0);
        @(negedge clk);
        run = 1'b0;
        reset_n = 1'b1;

        // reset in the middle of EX_ALU drops every strobe at once
        push_idle();
        gen_instr(8'h12, 1'b0, 1'b0, 0, 0, 1'b1);
        run_trace(1'b0, 1);
        e = q.pop_front();
        @(posedge clk);
        #1;
        run = e.run;  mem_ready = e.rdy;  ir = e.irv;
        #1 chk("exalu_before_reset", obs_m, e.exp);
        #1 reset_n = 1'b0;
        #1 chk("exalu_reset", obs_m, 21'd0);
        @(negedge clk);
        run = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", obs_m, 21'd0);

        // WAIT_LIMIT=4 instance: 3 waits are tolerated, the 4th times out
        reset_n = 1'b0;
        reset_w_n = 1'b1;
        @(negedge clk);
        chk("w_reset_idle", obs_w, 21'd0);
        push_idle();
        gen_instr(8'h20, 1'b0, 1'b0, 3, 3, 1'b1);
        gen_instr(8'h00, 1'b0, 1'b0, 3, 0, 1'b1);
        cyc = 0;
        icyc(1'b1, 1'b0, 3'd1, S_MAR, 3'd0, 1'b0);
        repeat (4) icyc(1'b1, 1'b0, 3'd2, S_MRD, 3'd0, 1'b0);
        repeat (5) push(rb(), rb(), 3'd0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 4'd0);
        run_trace(1'b1, 0);
        reset_w_n = 1'b0;
        #1 chk("w_reset_clears_err", obs_w, 21'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Fetch/decode/execute control sequencer for the 8-bit single-bus CPU.
- Each cycle it selects exactly one bus driver (PC, memory, reg A, reg B or ALU) and pulses the write strobes of the destination registers.
- It runs the ALU opcode, advances the PC and handshakes with memory using wait states.
- It sits between the IR/flag registers and the register, ALU and PC enable and write controls.

Parameters:
WAIT_LIMIT, 0, maximum number of mem_ready wait cycles before a bus error; 0 means unlimited.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
run  in  1  permits a new instruction fetch
ir  in  8  opcode held in the IR register
flag_z  in  1  registered ALU zero flag
flag_c  in  1  registered ALU carry flag
mem_ready  in  1  memory data valid on the bus this cycle
drv_sel  out  3  bus driver: 0 NONE, 1 PC, 2 MEM, 3 REGA, 4 REGB, 5 ALU
mem_rd  out  1  memory read request
mar_we  out  1  MAR write strobe
ir_we  out  1  IR write strobe
rega_we  out  1  register A write strobe
regb_we  out  1  register B write strobe
pc_we  out  1  PC load from bus
pc_inc  out  1  PC increment
flags_we  out  1  ALU flag register write strobe
alu_op  out  3  ALU opcode: 000 ADD, 001 SUB, 010 INC, 011 DEC, 100 AND, 101 OR, 110 XOR, 111 ADC
step  out  4  cycle index within the current instruction
halted  out  1  sequencer is in HALT
illegal_op  out  1  one-cycle pulse on an undefined opcode
bus_err  out  1  sticky flag: memory wait timeout

Behaviour:
- Opcodes:
  - 0x00 NOP; 0x01 HLT.
  - 0x10-0x17 ALU: A <= A op B, with op = ir[2:0].
  - 0x20 LDA #imm; 0x21 LDB #imm; 0x22 MOV B,A (B <= A); 0x23 MOV A,B (A <= B).
  - 0x30 JMP addr; 0x31 JZ addr; 0x32 JC addr.
  - Any other value is illegal.
- States and per-state outputs (outputs are a combinational function of state, mem_ready, ir and flags; every output not listed is 0):
  - IDLE: everything 0. Go to FA when run=1.
  - FA: drv=PC, mar_we=1. Go to FD.
  - FD: mem_rd=1, drv=MEM. When mem_ready=1: ir_we=1, pc_inc=1, go to DEC. Otherwise stay in FD.
  - DEC: drives nothing; branches on ir.
    - NOP or illegal: go to FA if run=1, else IDLE. Illegal also pulses illegal_op.
    - HLT: go to HALT.
    - ALU: go to EX_ALU.
    - MOV: go to EX_MOV.
    - LDA, LDB, JMP, taken JZ/JC: go to OA.
    - JZ with flag_z=0, JC with flag_c=0: go to SKIP.
  - EX_ALU: drv=ALU, alu_op=ir[2:0], rega_we=1, flags_we=1. Then go to FA or IDLE (per run).
  - EX_MOV: 0x22 drives drv=REGA with regb_we=1; 0x23 drives drv=REGB with rega_we=1. Then FA or IDLE.
  - SKIP: pc_inc=1. Then FA or IDLE.
  - OA: drv=PC, mar_we=1. Go to OD.
  - OD: mem_rd=1, drv=MEM. When mem_ready=1:
    - LDA: rega_we=1 and pc_inc=1.
    - LDB: regb_we=1 and pc_inc=1.
    - Jumps: pc_we=1, with no pc_inc.
    - Then FA or IDLE.
  - HALT: everything 0, halted=1. Only reset leaves HALT.
- Timing with mem_ready tied high:
  - NOP takes 3 cycles.
  - ALU, MOV and a not-taken jump take 4 cycles.
  - LDx and a taken jump take 5 cycles.
  - Each wait cycle adds 1.
- drv_sel never selects more than one source. alu_op is 000 outside EX_ALU.
- Write strobes pulse exactly once per event. During a wait, mem_rd and drv=MEM are held and no destination strobe fires.
- step:
  - 0 in FA; increments every cycle.
  - Saturates at 15.
  - 0 in IDLE and HALT.
- run is sampled only at instruction boundaries. An instruction already started always completes.
- WAIT_LIMIT > 0:
  - Count consecutive cycles in FD/OD with mem_ready=0.
  - When the count reaches WAIT_LIMIT, set bus_err=1 and go to HALT on the next edge.
  - The count clears on entry to FD/OD.
- Reset:
  - reset_n=0 immediately forces IDLE, step=0, bus_err=0 and every output to 0, including in the middle of an instruction or a wait.
  - The first possible fetch is the first rising edge after release that has run=1.

Decomposition:
- Package risc8_pkg holds:
  - state encoding;
  - DRV_* codes for drv_sel;
  - OP_* opcode constants;
  - ALU_* codes, identical to the ALU's.
- Sub-module bus_seq_decode: combinational opcode classifier (class, alu_op, jump-taken, illegal). The FSM, step counter and wait counter stay in bus_sequencer.

Test Plan:
- Reset, then run=1, memory returns 0x00 with ready=1:
  - Cycle 1: drv=1, mar_we=1.
  - Cycle 2: drv=2, mem_rd, ir_we, pc_inc.
  - Cycle 3: DEC, then FA with step back at 0; step reads 0,1,2.
- ir=0x17 (ADC): cycle 4 shows drv=5, alu_op=111, rega_we=1, flags_we=1 for exactly one cycle.
- LDA, operand 0x5A, mem_ready low for 2 cycles in OD:
  - mem_rd held 3 cycles.
  - rega_we and pc_inc fire once, on the ready cycle.
  - pc_inc totals 2 for the instruction.
- ir=0x31 (JZ):
  - flag_z=0: SKIP cycle with pc_inc=1, no mem_rd after DEC.
  - flag_z=1: OD cycle with drv=2 and pc_we=1, no pc_inc.
- ir=0xFF: illegal_op pulses once and the sequencer returns to FA. ir=0x01: halted stays 1 with all strobes 0 until reset_n=0.
- WAIT_LIMIT=4, mem_ready held low in FD: bus_err=1 after 4 wait cycles, then HALT. Separately, reset_n=0 mid EX_ALU drops all strobes to 0 in the same cycle.
